// File: rtl/dm_responder.sv
// Data-memory responder: clears its word array after reset, then serves CPU reads and
// byte-masked writes, emitting a one-cycle trace record and a wrapping count per committed write.
module dm_responder #(
    parameter int DEPTH = 3072,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [31:0]      m_data_addr,
    input  logic [31:0]      m_data_wdata,
    input  logic [3:0]       m_data_byteen,
    input  logic [31:0]      m_inst_addr,
    output logic [31:0]      m_data_rdata,
    output logic             ready,
    output logic             trace_valid,
    output logic [31:0]      trace_pc,
    output logic [31:0]      trace_addr,
    output logic [31:0]      trace_data,
    output logic             err_oob,
    output logic [CNT_W-1:0] wr_count
);

    typedef enum logic {
        CLEAR = 1'b0,
        RUN   = 1'b1
    } state_t;

    localparam logic [11:0] LAST_IDX   = 12'(DEPTH - 1);
    localparam logic [31:0] BYTE_LIMIT = 32'(DEPTH * 4);

    state_t      r_state;
    state_t      w_next_state;
    logic [11:0] r_clr_idx;
    logic [31:0] r_mem [DEPTH];

    logic [11:0] w_idx;
    logic        w_in_range;
    logic        w_wr_req;
    logic        w_commit;
    logic        w_reject;
    logic [31:0] w_old_word;
    logic [31:0] w_merged;

    assign w_idx      = m_data_addr[13:2];
    assign w_in_range = (m_data_addr < BYTE_LIMIT);
    assign w_wr_req   = |m_data_byteen;
    assign w_commit   = w_wr_req && w_in_range && (r_state == RUN);
    // Writes during the clear sweep are dropped and flagged, same as out-of-range ones.
    assign w_reject   = w_wr_req && (!w_in_range || (r_state == CLEAR));

    assign w_old_word   = w_in_range ? r_mem[w_idx] : '0;
    assign m_data_rdata = (r_state == RUN) ? w_old_word : '0;

    always_comb begin
        // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
        w_merged = w_old_word;
        for (int i = 0; i < 4; i++) begin
            if (m_data_byteen[i]) begin
                w_merged[8*i +: 8] = m_data_wdata[8*i +: 8];
            end
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state <= CLEAR;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_comb begin
        w_next_state = r_state;
        ready        = 1'b0;
        case (r_state)
            CLEAR: begin
                if (r_clr_idx == LAST_IDX) begin
                    w_next_state = RUN;
                end
            end
            RUN: begin
                ready = 1'b1;
            end
            default: w_next_state = CLEAR;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_clr_idx <= '0;
        end else if (r_state == CLEAR) begin
            r_clr_idx <= r_clr_idx + 12'd1;
        end
    end

    // NOTE: the memory has no reset; the CLEAR sweep zeroes it one word per cycle instead.
    always_ff @(posedge clk) begin
        if (r_state == CLEAR) begin
            r_mem[r_clr_idx] <= '0;
        end else if (w_commit) begin
            r_mem[w_idx] <= w_merged;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            trace_valid <= 1'b0;
            trace_pc    <= '0;
            trace_addr  <= '0;
            trace_data  <= '0;
            err_oob     <= 1'b0;
            wr_count    <= '0;
        end else begin
            trace_valid <= w_commit;
            if (w_commit) begin
                trace_pc   <= m_inst_addr;
                trace_addr <= {m_data_addr[31:2], 2'b00};
                trace_data <= w_merged;
                wr_count   <= wr_count + 1'b1;
            end
            if (w_reject) begin
                err_oob <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_dm_responder.sv
// Randomized scoreboard bench for dm_responder: a word-array reference model predicts reads,
// flags and counts; expected trace records are queued and matched by an independent monitor.
module tb_dm_responder;

    localparam int DEPTH = 3072;
    localparam int CNT_W = 16;
    localparam logic [31:0] BYTE_LIMIT = 32'(DEPTH * 4);

    logic             clk = 1'b0;
    logic             reset = 1'b0;
    logic [31:0]      m_data_addr = '0;
    logic [31:0]      m_data_wdata = '0;
    logic [3:0]       m_data_byteen = '0;
    logic [31:0]      m_inst_addr = '0;
    logic [31:0]      m_data_rdata;
    logic             ready;
    logic             trace_valid;
    logic [31:0]      trace_pc;
    logic [31:0]      trace_addr;
    logic [31:0]      trace_data;
    logic             err_oob;
    logic [CNT_W-1:0] wr_count;

    always #5 clk = ~clk;

    dm_responder #(.DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
        .clk          (clk),
        .reset        (reset),
        .m_data_addr  (m_data_addr),
        .m_data_wdata (m_data_wdata),
        .m_data_byteen(m_data_byteen),
        .m_inst_addr  (m_inst_addr),
        .m_data_rdata (m_data_rdata),
        .ready        (ready),
        .trace_valid  (trace_valid),
        .trace_pc     (trace_pc),
        .trace_addr   (trace_addr),
        .trace_data   (trace_data),
        .err_oob      (err_oob),
        .wr_count     (wr_count)
    );

    typedef struct {
        logic [31:0] pc;
        logic [31:0] addr;
        logic [31:0] data;
        int          due;
    } trace_t;

    trace_t      exp_q[$];
    logic [31:0] model_mem [DEPTH];
    int          model_edges;
    int          model_commits;
    logic        model_err;
    int          cyc = 0;
    int          n_vec = 0;
    int          n_fail = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic logic [31:0] merge(input logic [31:0] old_w, input logic [31:0] wdata,
                                          input logic [3:0] be);
        logic [31:0] w;
        w = old_w;
        for (int b = 0; b < 4; b++) begin
            if (be[b]) w[8*b +: 8] = wdata[8*b +: 8];
        end
        return w;
    endfunction

    task automatic model_clear();
        for (int i = 0; i < DEPTH; i++) model_mem[i] = '0;
        model_err     = 1'b0;
        model_commits = 0;
        model_edges   = 0;
        exp_q.delete();
    endtask

    task automatic check_reset_outputs();
        check("rst_rdata",  m_data_rdata, 32'h0);
        check("rst_ready",  {31'b0, ready}, 32'h0);
        check("rst_tvalid", {31'b0, trace_valid}, 32'h0);
        check("rst_tpc",    trace_pc, 32'h0);
        check("rst_taddr",  trace_addr, 32'h0);
        check("rst_tdata",  trace_data, 32'h0);
        check("rst_err",    {31'b0, err_oob}, 32'h0);
        check("rst_count",  {16'b0, wr_count}, 32'h0);
    endtask

    // One bus cycle: drive just after an edge, check at the falling edge, then apply the
    // effect of this cycle to the model (it becomes visible after the next rising edge).
    task automatic do_cycle(input logic [31:0] addr, input logic [31:0] wdata,
                            input logic [3:0] be, input logic [31:0] pc);
        logic        exp_ready;
        logic        in_range;
        int          idx;
        logic [31:0] exp_rdata;
        logic [31:0] new_w;
        trace_t      t;
        m_data_addr   = addr;
        m_data_wdata  = wdata;
        m_data_byteen = be;
        m_inst_addr   = pc;
        @(negedge clk);
        exp_ready = (model_edges >= DEPTH);
        in_range  = (addr < BYTE_LIMIT);
        idx       = int'(addr[13:2]);
        exp_rdata = (exp_ready && in_range) ? model_mem[idx] : 32'h0;
        check("rdata",    m_data_rdata, exp_rdata);
        check("ready",    {31'b0, ready}, {31'b0, exp_ready});
        check("err_oob",  {31'b0, err_oob}, {31'b0, model_err});
        check("wr_count", {16'b0, wr_count}, 32'(model_commits % (1 << CNT_W)));
        if (be != 4'b0) begin
            if (!exp_ready || !in_range) begin
                model_err = 1'b1;
            end else begin
                new_w = merge(model_mem[idx], wdata, be);
                model_mem[idx] = new_w;
                model_commits++;
                t.pc   = pc;
                t.addr = addr & 32'hFFFF_FFFC;
                t.data = new_w;
                t.due  = cyc + 1;
                exp_q.push_back(t);
            end
        end
        @(posedge clk);
        model_edges++;
        #1;
    endtask

    // Trace monitor: independent of stimulus, matches each pulse against the queue head.
    always @(negedge clk) begin
        if (reset) begin
            logic exp_tv;
            exp_tv = (exp_q.size() > 0) && (exp_q[0].due == cyc);
            check("trace_valid", {31'b0, trace_valid}, {31'b0, exp_tv});
            if (exp_tv) begin
                if (trace_valid) begin
                    check("trace_pc",   trace_pc,   exp_q[0].pc);
                    check("trace_addr", trace_addr, exp_q[0].addr);
                    check("trace_data", trace_data, exp_q[0].data);
                end
                void'(exp_q.pop_front());
            end
        end
    end

    initial begin
        logic [31:0] a;
        logic [3:0]  be;
        int          r;

        model_clear();
        repeat (3) @(posedge clk);
        #1;
        check_reset_outputs();
        reset = 1'b1;

        // First clear sweep with random read-only traffic.
        for (int i = 0; i < DEPTH; i++) do_cycle($urandom, $urandom, 4'b0, $urandom);
        do_cycle(32'h0000, 32'h0, 4'b0, 32'h0);
        do_cycle(32'h2FFC, 32'h0, 4'b0, 32'h0);
        check("ready_up", {31'b0, ready}, 32'h1);

        // Full-word write followed by a single-lane merge.
        do_cycle(32'h0010, 32'h1122_3344, 4'b1111, $urandom);
        do_cycle(32'h0011, 32'h0000_AA00, 4'b0010, $urandom);
        do_cycle(32'h0010, 32'h0, 4'b0, 32'h0);
        check("merge_word", m_data_rdata, 32'h1122_AA44);
        check("count_two",  {16'b0, wr_count}, 32'd2);

        // First out-of-range address.
        do_cycle(32'h3000, 32'hDEAD_BEEF, 4'b1111, $urandom);
        do_cycle(32'h3000, 32'h0, 4'b0, 32'h0);
        check("oob_err",   {31'b0, err_oob}, 32'h1);
        check("oob_count", {16'b0, wr_count}, 32'd2);
        check("oob_rdata", m_data_rdata, 32'h0);

        // Write-then-read: old value during the write cycle, new value afterwards.
        do_cycle(32'h0020, 32'h0000_0005, 4'b1111, $urandom);
        do_cycle(32'h0020, 32'h0, 4'b0, 32'h0);
        check("wr_then_rd", m_data_rdata, 32'h5);

        // Mixed random traffic, biased to a small window so reads hit written words.
        for (int i = 0; i < 2000; i++) begin
            r  = $urandom_range(0, 9);
            be = 4'($urandom_range(1, 15));
            if (r < 4)       a = $urandom_range(0, 255);
            else if (r < 6)  a = $urandom_range(0, DEPTH * 4 - 1);
            else if (r == 6) a = (r[0]) ? $urandom : BYTE_LIMIT - 4 + $urandom_range(0, 7);
            else             a = $urandom_range(0, 255);
            if (r >= 7) be = 4'b0;
            do_cycle(a, $urandom, be, $urandom);
        end

        // Back-to-back commits until the write counter wraps.
        while (model_commits < 65536) begin
            do_cycle($urandom_range(0, DEPTH * 4 - 1), $urandom, 4'($urandom_range(1, 15)), $urandom);
        end
        do_cycle(32'h0020, 32'h0, 4'b0, 32'h0);
        check("count_wrap", {16'b0, wr_count}, 32'h0);

        // Reset pulse mid-RUN: outputs must drop without waiting for a clock edge.
        m_data_addr = 32'h0020;
        reset = 1'b0;
        #1;
        check_reset_outputs();
        model_clear();
        @(posedge clk);
        #1;
        reset = 1'b1;

        // Second clear sweep with writes attempted before ready.
        for (int i = 0; i < DEPTH; i++) begin
            if (i == 100)      do_cycle(32'h0004, $urandom, 4'b1111, $urandom);
            else if (i == 200) do_cycle(32'h0020, $urandom, 4'b1111, $urandom);
            else               do_cycle($urandom_range(0, 255), 32'h0, 4'b0, 32'h0);
        end
        do_cycle(32'h0004, 32'h0, 4'b0, 32'h0);
        check("clr_wr_rd",  m_data_rdata, 32'h0);
        check("clr_wr_err", {31'b0, err_oob}, 32'h1);
        do_cycle(32'h0020, 32'h0, 4'b0, 32'h0);
        check("rst_wiped", m_data_rdata, 32'h0);
        for (int i = 0; i < 50; i++) do_cycle($urandom_range(0, 511), 32'h0, 4'b0, 32'h0);

        repeat (3) do_cycle(32'h0, 32'h0, 4'b0, 32'h0);
        check("trace_q_empty", 32'(exp_q.size()), 32'h0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule
